// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV32I load/store funct3 encodings and LSU FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Load/store access size and signedness encodings carried in funct3.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // MEM-stage access sequencer states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational byte-lane steering for loads and stores.
//                Produces byte enables, lane-replicated store data, the
//                sign/zero-extended load value and a misalignment flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [XLEN-1:0]   st_data,
    input  logic [XLEN-1:0]   rd_word,
    output logic [XLEN/8-1:0] byte_en,
    output logic [XLEN-1:0]   st_data_lane,
    output logic [XLEN-1:0]   ld_data,
    output logic              misalign
);

    localparam int c_NB = XLEN / 8;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selected from the read word by the low address bits.
    assign w_byte = rd_word[{addr_lo, 3'b000} +: 8];
    assign w_half = rd_word[{addr_lo[1], 4'b0000} +: 16];

    // Decode size/sign, steer lanes and flag illegal alignment or encodings.
    always_comb begin
        byte_en      = '0;
        st_data_lane = '0;
        ld_data      = '0;
        misalign     = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en      = {{(c_NB-1){1'b0}}, 1'b1} << addr_lo;
                st_data_lane = {c_NB{st_data[7:0]}};
                ld_data      = {{(XLEN-8){w_byte[7] & (funct3 == F3_B)}}, w_byte};
            end
            F3_H, F3_HU: begin
                misalign     = addr_lo[0];
                byte_en      = addr_lo[0] ? '0 : ({{(c_NB-2){1'b0}}, 2'b11} << addr_lo);
                st_data_lane = {(c_NB/2){st_data[15:0]}};
                ld_data      = {{(XLEN-16){w_half[15] & (funct3 == F3_H)}}, w_half};
            end
            F3_W: begin
                misalign     = (addr_lo != 2'b00);
                byte_en      = (addr_lo != 2'b00) ? '0 : '1;
                st_data_lane = st_data;
                ld_data      = rd_word;
            end
            default: begin
                misalign     = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu
//  Description : Pipeline MEM stage with internal word-organised data memory,
//                configurable access latency with stall handshake, misalign
//                detection, flush, and the MEM/WB pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LATENCY = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] alu_res_ex,
    input  logic [XLEN-1:0] rs2_val_ex,
    input  logic [4:0]      rd_ex,
    input  logic [2:0]      funct3_ex,
    input  logic            valid_ex,
    input  logic            mem_read_ex,
    input  logic            mem_write_ex,
    input  logic            reg_write_ex,
    input  logic            mem_to_reg_ex,
    input  logic            flush,
    output logic            stall_mem,
    output logic [XLEN-1:0] mem_data_mem,
    output logic [XLEN-1:0] alu_res_mem,
    output logic [4:0]      rd_mem,
    output logic            reg_write_mem,
    output logic            mem_to_reg_mem,
    output logic            valid_mem,
    output logic            misalign_mem
);

    localparam int         c_AW  = $clog2(DEPTH_WORDS);
    localparam int         c_NB  = XLEN / 8;
    localparam logic [2:0] c_LAT = 3'(MEM_LATENCY);

    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    lsu_state_t      r_state;
    lsu_state_t      w_state_nxt;
    logic [2:0]      r_cnt;
    logic [2:0]      w_cnt_nxt;

    logic [c_AW-1:0] w_idx;
    logic [XLEN-1:0] w_rd_word;
    logic [c_NB-1:0] w_be;
    logic [XLEN-1:0] w_st_lane;
    logic [XLEN-1:0] w_ld_ext;
    logic            w_mis_raw;
    logic            w_mem_op;
    logic            w_mis;
    logic            w_qual;
    logic            w_complete;
    logic            w_stall;
    logic            w_store;

    // Upper address bits are dropped so accesses wrap over the array.
    assign w_idx     = alu_res_ex[c_AW+1:2];
    assign w_rd_word = r_mem[w_idx];

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3       (funct3_ex),
        .addr_lo      (alu_res_ex[1:0]),
        .st_data      (rs2_val_ex),
        .rd_word      (w_rd_word),
        .byte_en      (w_be),
        .st_data_lane (w_st_lane),
        .ld_data      (w_ld_ext),
        .misalign     (w_mis_raw)
    );

    assign w_mem_op = valid_ex & (mem_read_ex | mem_write_ex);
    assign w_mis    = w_mem_op & w_mis_raw;
    assign w_qual   = w_mem_op & ~w_mis_raw;

    // Sequencer: decide stall, completion edge and next state/counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_complete  = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_qual && (c_LAT != 3'd0)) begin
                    w_stall     = 1'b1;
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = c_LAT;
                end else begin
                    w_complete  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 3'd1) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_stall     = 1'b1;
                    w_cnt_nxt   = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
        end
    end

    // Stall is forced low while reset is held so every output reads zero.
    assign stall_mem = w_stall & rst_n;

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A store commits only on an unflushed completing edge outside reset.
    assign w_store = rst_n & ~flush & w_complete & w_qual & mem_write_ex;

    // Byte-masked write into the data array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_store) begin
            for (int b = 0; b < c_NB; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_st_lane[8*b +: 8];
                end
            end
        end
    end

    // MEM/WB register: bubble on flush, load on completion, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data_mem   <= '0;
            alu_res_mem    <= '0;
            rd_mem         <= 5'd0;
            reg_write_mem  <= 1'b0;
            mem_to_reg_mem <= 1'b0;
            valid_mem      <= 1'b0;
            misalign_mem   <= 1'b0;
        end else if (flush) begin
            mem_data_mem   <= '0;
            alu_res_mem    <= '0;
            rd_mem         <= 5'd0;
            reg_write_mem  <= 1'b0;
            mem_to_reg_mem <= 1'b0;
            valid_mem      <= 1'b0;
            misalign_mem   <= 1'b0;
        end else if (w_complete) begin
            mem_data_mem   <= (w_qual & mem_read_ex & ~mem_write_ex) ? w_ld_ext : '0;
            alu_res_mem    <= alu_res_ex;
            rd_mem         <= rd_ex;
            reg_write_mem  <= valid_ex & reg_write_ex & ~w_mis;
            mem_to_reg_mem <= mem_to_reg_ex;
            valid_mem      <= valid_ex;
            misalign_mem   <= w_mis;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mem_stage_lsu
//  Description : Self-checking bench for mem_stage_lsu with two instances,
//                MEM_LATENCY=0 (index 0) and MEM_LATENCY=3 (index 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic [31:0] alu [2];
    logic [31:0] rs2 [2];
    logic [4:0]  rd [2];
    logic [2:0]  f3 [2];
    logic        v [2], mr [2], mw [2], rw [2], m2r [2], fl [2];
    logic        stall [2];
    logic [31:0] o_data [2], o_alu [2];
    logic [4:0]  o_rd [2];
    logic        o_rw [2], o_m2r [2], o_v [2], o_mis [2];

    // Expected MEM/WB view kept by the model.
    logic [31:0] exp_data [2], exp_alu [2];
    logic [4:0]  exp_rd [2];
    logic        exp_rw [2], exp_m2r [2], exp_v [2], exp_mis [2], exp_stall [2];
    bit          busy [2];
    int          stall_seen [2];
    int          stall_tot [2];
    logic [7:0]  mb [2][1024];
    logic [76:0] snap [2];
    logic        snap_st [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.XLEN(32), .DEPTH_WORDS(256), .MEM_LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .alu_res_ex(alu[0]), .rs2_val_ex(rs2[0]),
        .rd_ex(rd[0]), .funct3_ex(f3[0]), .valid_ex(v[0]), .mem_read_ex(mr[0]),
        .mem_write_ex(mw[0]), .reg_write_ex(rw[0]), .mem_to_reg_ex(m2r[0]),
        .flush(fl[0]), .stall_mem(stall[0]), .mem_data_mem(o_data[0]),
        .alu_res_mem(o_alu[0]), .rd_mem(o_rd[0]), .reg_write_mem(o_rw[0]),
        .mem_to_reg_mem(o_m2r[0]), .valid_mem(o_v[0]), .misalign_mem(o_mis[0]));

    mem_stage_lsu #(.XLEN(32), .DEPTH_WORDS(256), .MEM_LATENCY(3)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .alu_res_ex(alu[1]), .rs2_val_ex(rs2[1]),
        .rd_ex(rd[1]), .funct3_ex(f3[1]), .valid_ex(v[1]), .mem_read_ex(mr[1]),
        .mem_write_ex(mw[1]), .reg_write_ex(rw[1]), .mem_to_reg_ex(m2r[1]),
        .flush(fl[1]), .stall_mem(stall[1]), .mem_data_mem(o_data[1]),
        .alu_res_mem(o_alu[1]), .rd_mem(o_rd[1]), .reg_write_mem(o_rw[1]),
        .mem_to_reg_mem(o_m2r[1]), .valid_mem(o_v[1]), .misalign_mem(o_mis[1]));

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d got=%h want=%h t=%0t", nm, d, got, want, $time);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    function automatic bit model_mis(input logic [2:0] f, input logic [1:0] a);
        case (f)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            3'b010:         return (a != 2'b00);
            default:        return 1'b1;
        endcase
    endfunction

    function automatic int model_size(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [2:0] f, input logic [31:0] a);
        int          ba = int'(a[9:0]);
        logic [31:0] r  = 32'd0;
        for (int i = 0; i < model_size(f); i++) r[8*i +: 8] = mb[d][ba+i];
        if (f == 3'b000) r = {{24{r[7]}}, r[7:0]};
        if (f == 3'b001) r = {{16{r[15]}}, r[15:0]};
        return r;
    endfunction

    task automatic model_store(input int d, input logic [2:0] f, input logic [31:0] a, input logic [31:0] data);
        int ba = int'(a[9:0]);
        for (int i = 0; i < model_size(f); i++) mb[d][ba+i] = data[8*i +: 8];
    endtask

    task automatic exp_zero(input int d);
        exp_data[d] = 32'd0; exp_alu[d] = 32'd0; exp_rd[d] = 5'd0;
        exp_rw[d] = 1'b0; exp_m2r[d] = 1'b0; exp_v[d] = 1'b0; exp_mis[d] = 1'b0;
    endtask

    task automatic drive_nop(input int d);
        alu[d] = 32'd0; rs2[d] = 32'd0; rd[d] = 5'd0; f3[d] = 3'd0;
        v[d] = 1'b0; mr[d] = 1'b0; mw[d] = 1'b0; rw[d] = 1'b0; m2r[d] = 1'b0;
    endtask

    function automatic logic [76:0] pack_in(input int d);
        return {alu[d], rs2[d], rd[d], f3[d], v[d], mr[d], mw[d], rw[d], m2r[d]};
    endfunction

    // Idle instances see all-zero inputs, so MEM/WB settles to zero.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!busy[d]) begin
                exp_zero(d);
                exp_stall[d] = 1'b0;
            end
        end
    end

    // EX/MEM inputs must not move while the stage reports a stall.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (snap_st[d] === 1'b1) chk("hold_inputs", d, {31'd0, pack_in(d) !== snap[d]}, 32'd0);
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk("stall_mem", d, {31'd0, stall[d]}, {31'd0, exp_stall[d]});
            chk("mem_data_mem", d, o_data[d], exp_data[d]);
            chk("alu_res_mem", d, o_alu[d], exp_alu[d]);
            chk("rd_mem", d, 32'(o_rd[d]), 32'(exp_rd[d]));
            chk("reg_write_mem", d, {31'd0, o_rw[d]}, {31'd0, exp_rw[d]});
            chk("mem_to_reg_mem", d, {31'd0, o_m2r[d]}, {31'd0, exp_m2r[d]});
            chk("valid_mem", d, {31'd0, o_v[d]}, {31'd0, exp_v[d]});
            chk("misalign_mem", d, {31'd0, o_mis[d]}, {31'd0, exp_mis[d]});
            if (stall[d] === 1'b1) begin
                stall_seen[d]++;
                stall_tot[d]++;
            end
            snap[d]    = pack_in(d);
            snap_st[d] = stall[d];
        end
    end

    // Present one instruction, follow it to completion, flush or reset.
    task automatic run_op(input int d, input bit iv, input bit imr, input bit imw, input bit irw,
                          input bit im2r, input logic [2:0] if3, input logic [31:0] iaddr,
                          input logic [31:0] idata, input logic [4:0] ird,
                          input int flush_at, input int rst_at);
        bit          mis;
        bit          qual;
        int          lat;
        logic [31:0] ld;
        busy[d] = 1'b1;
        alu[d] = iaddr; rs2[d] = idata; rd[d] = ird; f3[d] = if3;
        v[d] = iv; mr[d] = imr; mw[d] = imw; rw[d] = irw; m2r[d] = im2r;
        mis  = iv && (imr || imw) && model_mis(if3, iaddr[1:0]);
        qual = iv && (imr || imw) && !mis;
        lat  = qual ? lat_of(d) : 0;
        stall_seen[d] = 0;
        for (int k = 0; k <= lat; k++) begin
            exp_stall[d] = (k < lat);
            if (k == flush_at) fl[d] = 1'b1;
            if (k == rst_at) begin
                #2;
                rst_n[d] = 1'b0;
                #1;
                chk("rst_stall", d, {31'd0, stall[d]}, 32'd0);
                chk("rst_valid", d, {31'd0, o_v[d]}, 32'd0);
                chk("rst_data", d, o_data[d], 32'd0);
                chk("rst_rw", d, {31'd0, o_rw[d]}, 32'd0);
                exp_zero(d);
                exp_stall[d] = 1'b0;
                drive_nop(d);
                @(posedge clk);
                @(posedge clk);
                #1;
                rst_n[d] = 1'b1;
                busy[d] = 1'b0;
                return;
            end
            @(posedge clk);
            if (k == flush_at) begin
                exp_zero(d);
                #1;
                fl[d] = 1'b0;
                exp_stall[d] = 1'b0;
                drive_nop(d);
                busy[d] = 1'b0;
                return;
            end
            if (k == lat) begin
                ld = (qual && imr && !imw) ? model_load(d, if3, iaddr) : 32'd0;
                if (qual && imw) model_store(d, if3, iaddr, idata);
                exp_data[d] = ld;
                exp_alu[d]  = iaddr;
                exp_rd[d]   = ird;
                exp_rw[d]   = iv && irw && !mis;
                exp_m2r[d]  = im2r;
                exp_v[d]    = iv;
                exp_mis[d]  = mis;
            end
            #1;
        end
        exp_stall[d] = 1'b0;
        drive_nop(d);
        busy[d] = 1'b0;
    endtask

    task automatic ld_op(input int d, input logic [2:0] f, input logic [31:0] a, input logic [4:0] r);
        run_op(d, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, f, a, 32'd0, r, -1, -1);
    endtask

    task automatic st_op(input int d, input logic [2:0] f, input logic [31:0] a, input logic [31:0] data);
        run_op(d, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, f, a, data, 5'd0, -1, -1);
    endtask

    task automatic alu_op(input int d, input logic [31:0] res, input logic [4:0] r);
        run_op(d, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, res, 32'd0, r, -1, -1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            fl[d] = 1'b0;
            drive_nop(d);
            exp_zero(d);
            exp_stall[d] = 1'b0;
            busy[d] = 1'b0;
            stall_seen[d] = 0;
            stall_tot[d] = 0;
            snap_st[d] = 1'b0;
            snap[d] = '0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Zero-latency instance.
        st_op(0, 3'b010, 32'd16, 32'd42);
        ld_op(0, 3'b010, 32'd16, 5'd5);
        chk("lw16_data", 0, o_data[0], 32'd42);
        chk("lw16_rd", 0, 32'(o_rd[0]), 32'd5);
        chk("lw16_rw", 0, {31'd0, o_rw[0]}, 32'd1);
        st_op(0, 3'b010, 32'd0, 32'h1122_3344);
        st_op(0, 3'b000, 32'd1, 32'h0000_0080);
        ld_op(0, 3'b000, 32'd1, 5'd1);
        chk("lb1", 0, o_data[0], 32'hFFFF_FF80);
        ld_op(0, 3'b100, 32'd1, 5'd2);
        chk("lbu1", 0, o_data[0], 32'h0000_0080);
        ld_op(0, 3'b001, 32'd2, 5'd3);
        chk("lh2", 0, o_data[0], 32'h0000_1122);
        ld_op(0, 3'b010, 32'd0, 5'd4);
        chk("lw0", 0, o_data[0], 32'h1122_8044);
        ld_op(0, 3'b010, 32'd18, 5'd6);
        chk("mis_flag", 0, {31'd0, o_mis[0]}, 32'd1);
        chk("mis_rw", 0, {31'd0, o_rw[0]}, 32'd0);
        ld_op(0, 3'b010, 32'd16, 5'd6);
        chk("after_mis", 0, o_data[0], 32'd42);
        ld_op(0, 3'b010, 32'd1040, 5'd7);
        chk("wrap", 0, o_data[0], 32'd42);
        run_op(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'd3, 32'h55, 5'd8, -1, -1);
        chk("rdwr_data", 0, o_data[0], 32'd0);
        ld_op(0, 3'b100, 32'd3, 5'd8);
        chk("rdwr_store", 0, o_data[0], 32'h0000_0055);
        st_op(0, 3'b001, 32'd22, 32'h1234_ABCD);
        ld_op(0, 3'b101, 32'd22, 5'd9);
        chk("lhu22", 0, o_data[0], 32'h0000_ABCD);
        ld_op(0, 3'b001, 32'd22, 5'd9);
        chk("lh22", 0, o_data[0], 32'hFFFF_ABCD);
        run_op(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 32'd16, 32'hDEAD, 5'd1, -1, -1);
        chk("inv_valid", 0, {31'd0, o_v[0]}, 32'd0);
        ld_op(0, 3'b010, 32'd16, 5'd2);
        chk("inv_nowrite", 0, o_data[0], 32'd42);
        chk("lat0_nostall", 0, 32'(stall_tot[0]), 32'd0);

        // Three-cycle-latency instance.
        st_op(1, 3'b010, 32'd16, 32'd42);
        ld_op(1, 3'b010, 32'd16, 5'd7);
        chk("lat3_stalls", 1, 32'(stall_seen[1]), 32'd3);
        chk("lat3_data", 1, o_data[1], 32'd42);
        alu_op(1, 32'h1234, 5'd3);
        chk("alu_res", 1, o_alu[1], 32'h1234);
        chk("alu_nostall", 1, 32'(stall_seen[1]), 32'd0);
        run_op(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'd16, 32'd7, 5'd0, 2, -1);
        chk("flush_valid", 1, {31'd0, o_v[1]}, 32'd0);
        alu_op(1, 32'h55AA, 5'd4);
        chk("flush_idle", 1, 32'(stall_seen[1]), 32'd0);
        ld_op(1, 3'b010, 32'd16, 5'd5);
        chk("flush_nostore", 1, o_data[1], 32'd42);
        run_op(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 32'd16, 32'd99, 5'd0, -1, 2);
        ld_op(1, 3'b010, 32'd16, 5'd6);
        chk("rst_nostore", 1, o_data[1], 32'd42);
        chk("rst_resume_stalls", 1, 32'(stall_seen[1]), 32'd3);
        ld_op(1, 3'b001, 32'd17, 5'd6);
        chk("mis_lat3_nostall", 1, 32'(stall_seen[1]), 32'd0);
        chk("mis_lat3_flag", 1, {31'd0, o_mis[1]}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
